i2c_reg_bank: RTL

Parametrised byte-wide register bank between the I2C slave byte interface and the Core fabric. It supersedes the fixed, hand-written register map with four generic regions:
- a paged OSD RAM write window;
- a bank of read/write control bytes with per-byte write strobes;
- a bank of 32-bit read-only status words read atomically, MSB first;
- a bank of self-timed pulse (command) registers.

---
 rtl/i2c_reg_bank_pkg.sv | 87 ++++++++
 rtl/i2c_reg_bank_pulse_gen.sv | 42 ++++
 rtl/i2c_reg_bank.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_pkg
//  Purpose  : Shared definitions for the I2C register bank: region enum,
//             decode result struct, default region map and the address
//             decoder / overlap helper functions.
//  Contents : region_e, decode_t, DEF_* defaults, decode_addr(),
//             ranges_overlap()
//  Revision : 1.0 - initial generic register bank
// ============================================================================
package reg_bank_pkg;

    typedef enum logic [2:0] {
        R_NONE  = 3'd0,
        R_OSD   = 3'd1,
        R_CTRL  = 3'd2,
        R_STAT  = 3'd3,
        R_PULSE = 3'd4
    } region_e;

    // index is the element number inside the region (byte, word or pulse),
    // lane is the byte position inside a 32-bit status word (0 = MSB).
    typedef struct packed {
        region_e     region;
        logic [7:0]  index;
        logic [1:0]  lane;
    } decode_t;

    // OSD RAM window occupies the whole lower half of the address space.
    localparam int OSD_SIZE        = 128;
    localparam int STAT_WORD_BYTES = 4;

    // Default region map.
    localparam int DEF_NUM_CTRL   = 16;
    localparam int DEF_CTRL_BASE  = 'h80;
    localparam int DEF_NUM_STAT   = 8;
    localparam int DEF_STAT_BASE  = 'hA0;
    localparam int DEF_NUM_PULSE  = 8;
    localparam int DEF_PULSE_BASE = 'hF0;
    localparam int DEF_PULSE_LEN  = 4;
    localparam int DEF_PAGE_BITS  = 3;

    // Half-open ranges [a, a+na) and [b, b+nb) share at least one address.
    function automatic bit ranges_overlap(input int a, input int na,
                                          input int b, input int nb);
        return (a < b + nb) && (b < a + na);
    endfunction

    // Map an address onto {region, index, lane}. Regions are exclusive, so
    // the order of the tests only matters for illegal parameter sets, which
    // are rejected at elaboration.
    function automatic decode_t decode_addr(input logic [7:0] addr,
                                            input int ctrl_base,
                                            input int num_ctrl,
                                            input int stat_base,
                                            input int num_stat,
                                            input int pulse_base,
                                            input int num_pulse);
        decode_t d;
        int      a;
        int      off;
        a        = int'(addr);
        off      = 0;
        d.region = R_NONE;
        d.index  = '0;
        d.lane   = '0;
        if (a < OSD_SIZE) begin
            d.region = R_OSD;
            d.index  = addr;
        end else if (a >= ctrl_base && a < ctrl_base + num_ctrl) begin
            d.region = R_CTRL;
            d.index  = 8'(a - ctrl_base);
        end else if (a >= stat_base &&
                     a < stat_base + STAT_WORD_BYTES * num_stat) begin
            off      = a - stat_base;
            d.region = R_STAT;
            d.index  = 8'(off / STAT_WORD_BYTES);
            d.lane   = 2'(off % STAT_WORD_BYTES);
        end else if (a >= pulse_base && a < pulse_base + num_pulse) begin
            d.region = R_PULSE;
            d.index  = 8'(a - pulse_base);
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_reg_bank_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pulse_gen
//  Purpose  : Self-timed command pulse. A load starts (or restarts) a down
//             counter at PULSE_LEN; the output is high while it is nonzero.
//  Ports    : clk      - system clock
//             reset_n  - synchronous active-low reset
//             load     - restart the pulse (one per cycle)
//             pulse    - command pulse output
//  Revision : 1.0 - initial generic register bank
// ============================================================================
module reg_pulse_gen #(
    parameter int PULSE_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic pulse
);

    localparam int               CNT_W    = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // A load always wins over the decrement so a rewrite during an active
    // pulse extends it to PULSE_LEN cycles after the latest write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign pulse = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/i2c_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_bank
//  Purpose  : Byte-wide register bank between the I2C slave byte interface
//             and the core fabric. Four regions: paged OSD RAM write window,
//             read/write control bytes, atomically read 32-bit status words
//             (MSB first) and self-timed command pulses.
//  Ports    : clk, reset_n        - clock, synchronous active-low reset
//             addr, data_in       - register address / write byte
//             write_en            - one write per cycle while high
//             data_out            - registered read byte (1-cycle latency)
//             ctrl_q, ctrl_wr_stb - control byte image / per-byte strobes
//             stat_in             - live status words, word k at [32k+31:32k]
//             pulse_out           - command pulses
//             ram_data/addr/wren  - OSD RAM write port
//  Revision : 1.0 - initial generic register bank
// ============================================================================
module i2c_reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                    NUM_CTRL   = DEF_NUM_CTRL,
    parameter int                    CTRL_BASE  = DEF_CTRL_BASE,
    parameter logic [NUM_CTRL*8-1:0] CTRL_RESET = '0,
    parameter int                    NUM_STAT   = DEF_NUM_STAT,
    parameter int                    STAT_BASE  = DEF_STAT_BASE,
    parameter int                    NUM_PULSE  = DEF_NUM_PULSE,
    parameter int                    PULSE_BASE = DEF_PULSE_BASE,
    parameter int                    PULSE_LEN  = DEF_PULSE_LEN,
    parameter int                    PAGE_BITS  = DEF_PAGE_BITS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             addr,
    input  logic [7:0]             data_in,
    input  logic                   write_en,
    output logic [7:0]             data_out,
    output logic [NUM_CTRL*8-1:0]  ctrl_q,
    output logic [NUM_CTRL-1:0]    ctrl_wr_stb,
    input  logic [NUM_STAT*32-1:0] stat_in,
    output logic [NUM_PULSE-1:0]   pulse_out,
    output logic [7:0]             ram_data,
    output logic [6+PAGE_BITS:0]   ram_addr,
    output logic                   ram_wren
);

    localparam int CTRL_IW  = (NUM_CTRL  > 1) ? $clog2(NUM_CTRL)  : 1;
    localparam int STAT_IW  = (NUM_STAT  > 1) ? $clog2(NUM_STAT)  : 1;
    localparam int PULSE_IW = (NUM_PULSE > 1) ? $clog2(NUM_PULSE) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time legality of the region map
    // ------------------------------------------------------------------
    localparam bit PARAM_BAD =
        (NUM_CTRL < 1) || (NUM_STAT < 1) || (NUM_PULSE < 1) ||
        (PULSE_LEN < 1) || (PAGE_BITS < 1) || (PAGE_BITS > 8) ||
        (CTRL_BASE  < OSD_SIZE) || (CTRL_BASE  + NUM_CTRL  > 256) ||
        (STAT_BASE  < OSD_SIZE) ||
        (STAT_BASE  + STAT_WORD_BYTES * NUM_STAT > 256) ||
        (PULSE_BASE < OSD_SIZE) || (PULSE_BASE + NUM_PULSE > 256) ||
        ranges_overlap(CTRL_BASE, NUM_CTRL,
                       STAT_BASE, STAT_WORD_BYTES * NUM_STAT) ||
        ranges_overlap(CTRL_BASE, NUM_CTRL, PULSE_BASE, NUM_PULSE) ||
        ranges_overlap(STAT_BASE, STAT_WORD_BYTES * NUM_STAT,
                       PULSE_BASE, NUM_PULSE);

    if (PARAM_BAD) begin : g_param_check
        $error("i2c_reg_bank: illegal or overlapping region parameters");
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    decode_t               w_dec;
    logic [CTRL_IW-1:0]    w_ctrl_idx;
    logic [STAT_IW-1:0]    w_stat_idx;
    logic [PULSE_IW-1:0]   w_pulse_idx;
    logic                  w_unused_idx;

    assign w_dec = decode_addr(addr, CTRL_BASE, NUM_CTRL, STAT_BASE,
                               NUM_STAT, PULSE_BASE, NUM_PULSE);

    // Every region is smaller than 256 entries; only the low index bits
    // are meaningful for a given region.
    assign w_ctrl_idx   = w_dec.index[CTRL_IW-1:0];
    assign w_stat_idx   = w_dec.index[STAT_IW-1:0];
    assign w_pulse_idx  = w_dec.index[PULSE_IW-1:0];
    assign w_unused_idx = ^w_dec.index;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]            r_data_out;
    logic [7:0]            r_ctrl [NUM_CTRL];
    logic [NUM_CTRL-1:0]   r_ctrl_wr_stb;
    logic [7:0]            r_ram_data;
    logic [6+PAGE_BITS:0]  r_ram_addr;
    logic                  r_ram_wren;
    logic [23:0]           r_shadow;
    logic [STAT_IW-1:0]    r_tag;
    logic                  r_tag_vld;
    logic [7:0]            r_prev_addr;
    logic [NUM_PULSE-1:0]  w_pulse;

    // ------------------------------------------------------------------
    // Status word selection and snapshot
    // ------------------------------------------------------------------
    logic [31:0] w_stat_word [NUM_STAT];
    logic [31:0] w_sel_word;
    logic [23:0] w_stat_low;
    logic        w_stat_entry;

    for (genvar k = 0; k < NUM_STAT; k++) begin : g_stat_unpack
        assign w_stat_word[k] = stat_in[32*k +: 32];
    end

    assign w_sel_word = w_stat_word[w_stat_idx];

    // A snapshot is taken only when the address arrives on a word MSB;
    // sitting on the MSB leaves the earlier snapshot untouched.
    assign w_stat_entry = (w_dec.region == R_STAT) && (w_dec.lane == 2'd0) &&
                          (addr != r_prev_addr);

    // The lower three bytes come from the shadow only for the word the
    // snapshot belongs to; any other word is read live.
    assign w_stat_low = (r_tag_vld && (r_tag == w_stat_idx)) ? r_shadow
                                                             : w_sel_word[23:0];

    // ------------------------------------------------------------------
    // Read mux (registered into data_out)
    // ------------------------------------------------------------------
    logic [7:0] w_rd_data;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_dec.region)
            R_CTRL:  w_rd_data = r_ctrl[w_ctrl_idx];
            R_STAT: begin
                case (w_dec.lane)
                    2'd0:    w_rd_data = w_sel_word[31:24];
                    2'd1:    w_rd_data = w_stat_low[23:16];
                    2'd2:    w_rd_data = w_stat_low[15:8];
                    default: w_rd_data = w_stat_low[7:0];
                endcase
            end
            R_PULSE: w_rd_data = {7'b0, w_pulse[w_pulse_idx]};
            default: w_rd_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_out    <= 8'h00;
            for (int i = 0; i < NUM_CTRL; i++) begin
                r_ctrl[i] <= CTRL_RESET[8*i +: 8];
            end
            r_ctrl_wr_stb <= '0;
            r_ram_data    <= '0;
            r_ram_addr    <= '0;
            r_ram_wren    <= 1'b0;
            r_shadow      <= '0;
            r_tag         <= '0;
            r_tag_vld     <= 1'b0;
            r_prev_addr   <= 8'h00;
        end else begin
            r_data_out    <= w_rd_data;
            r_prev_addr   <= addr;
            r_ctrl_wr_stb <= '0;
            r_ram_wren    <= 1'b0;

            // stat_in is sampled before the edge, so a word changing in
            // the capture cycle is snapshotted with its old value.
            if (w_stat_entry) begin
                r_shadow  <= w_sel_word[23:0];
                r_tag     <= w_stat_idx;
                r_tag_vld <= 1'b1;
            end

            if (write_en) begin
                case (w_dec.region)
                    R_OSD: begin
                        // Page comes from the already-registered page byte,
                        // so a page write only affects later OSD writes.
                        r_ram_data <= data_in;
                        r_ram_addr <= {r_ctrl[0][PAGE_BITS-1:0], addr[6:0]};
                        r_ram_wren <= 1'b1;
                    end
                    R_CTRL: begin
                        r_ctrl[w_ctrl_idx]        <= data_in;
                        r_ctrl_wr_stb[w_ctrl_idx] <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Command pulses
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PULSE; p++) begin : g_pulse
        logic w_load;
        assign w_load = write_en && (w_dec.region == R_PULSE) &&
                        (w_pulse_idx == PULSE_IW'(p));

        reg_pulse_gen #(
            .PULSE_LEN (PULSE_LEN)
        ) u_pulse (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (w_load),
            .pulse   (w_pulse[p])
        );
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CTRL; c++) begin : g_ctrl_out
        assign ctrl_q[8*c +: 8] = r_ctrl[c];
    end

    assign data_out    = r_data_out;
    assign ctrl_wr_stb = r_ctrl_wr_stb;
    assign pulse_out   = w_pulse;
    assign ram_data    = r_ram_data;
    assign ram_addr    = r_ram_addr;
    assign ram_wren    = r_ram_wren;

endmodule
`default_nettype wire
